// File: rtl/glitch_pkg.sv
// glitch_pkg: shared types and default widths for the glitch sequencer and
// anything that instantiates or drives it.
//   seq_state_t   - sequencer FSM states
//   glitch_mode_t - which injector input the sequencer drives
//   CNT_W_DEF     - default width of delay/width/gap counters and fields
//   SHOT_W_DEF    - default width of shot-count field and shots-fired counter
package glitch_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned SHOT_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4
  } seq_state_t;

  typedef enum logic {
    MODE_RANDOM   = 1'b0,
    MODE_SPECIFIC = 1'b1
  } glitch_mode_t;

endpackage

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: timing controller in front of the glitch injector.
// Armed with a latched configuration, it waits for a rising edge on trigger,
// counts a programmable delay, then emits `shots` pulses of `width` cycles
// separated by `gap` low cycles on the injector input selected by `mode`.
//
// Ports:
//   clk             - system clock, rising edge
//   reset           - asynchronous active-high reset
//   arm             - one-cycle request, latches config (IDLE only)
//   abort           - level, forces IDLE from any state
//   trigger         - synchronous event line, rising edge starts sequence
//   mode            - 0 drive enable, 1 drive enable_specific
//   delay           - cycles from trigger detect to first pulse
//   width           - pulse length in cycles (0 treated as 1)
//   gap             - low cycles between pulses (0 treated as 1)
//   shots           - number of pulses (0 treated as 1)
//   enable          - injector random-glitch enable
//   enable_specific - injector specific-value enable
//   busy            - high in every state except IDLE
//   done            - one-cycle pulse after the last pulse ends
//   shots_fired     - pulses completed since last arm
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned SHOT_W = SHOT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic              mode,
  input  logic [CNT_W-1:0]  delay,
  input  logic [CNT_W-1:0]  width,
  input  logic [CNT_W-1:0]  gap,
  input  logic [SHOT_W-1:0] shots,
  output logic              enable,
  output logic              enable_specific,
  output logic              busy,
  output logic              done,
  output logic [SHOT_W-1:0] shots_fired
);

  seq_state_t   state, state_nxt;
  glitch_mode_t cfg_mode;
  logic [CNT_W-1:0]  cfg_delay, cfg_width, cfg_gap;
  logic [SHOT_W-1:0] cfg_shots;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SHOT_W-1:0] fired_nxt;
  logic              trig_q;
  logic              trig_rise;
  logic              latch_cfg;
  logic              done_nxt;

  assign trig_rise = trigger && !trig_q;

  // Every state, including PULSE and GAP, is entered at the edge that begins
  // its first cycle, and the registered outputs are decoded from the next
  // state. To put the first pulse D+1 edges after the detecting edge, the
  // detect always passes through DELAY with the counter loaded to D; D=0
  // therefore costs exactly one DELAY cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fired_nxt = shots_fired;
    done_nxt  = 1'b0;
    latch_cfg = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            latch_cfg = 1'b1;
            fired_nxt = '0;
            state_nxt = ARMED;
          end
        end
        ARMED: begin
          if (trig_rise) begin
            cnt_nxt   = cfg_delay;
            state_nxt = DELAY;
          end
        end
        DELAY: begin
          if (cnt == '0) begin
            cnt_nxt   = cfg_width - CNT_W'(1);
            state_nxt = PULSE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            fired_nxt = shots_fired + SHOT_W'(1);
            if (fired_nxt == cfg_shots) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              cnt_nxt   = cfg_gap - CNT_W'(1);
              state_nxt = GAP;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            cnt_nxt   = cfg_width - CNT_W'(1);
            state_nxt = PULSE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      trig_q          <= 1'b0;
      shots_fired     <= '0;
      enable          <= 1'b0;
      enable_specific <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      trig_q          <= trigger;
      shots_fired     <= fired_nxt;
      enable          <= (state_nxt == PULSE) && (cfg_mode == MODE_RANDOM);
      enable_specific <= (state_nxt == PULSE) && (cfg_mode == MODE_SPECIFIC);
      busy            <= (state_nxt != IDLE);
      done            <= done_nxt;
    end
  end

  // Zero in width/gap/shots is promoted to 1 so the down-counters never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_mode  <= MODE_RANDOM;
      cfg_delay <= '0;
      cfg_width <= '0;
      cfg_gap   <= '0;
      cfg_shots <= '0;
    end else if (latch_cfg) begin
      cfg_mode  <= glitch_mode_t'(mode);
      cfg_delay <= delay;
      cfg_width <= (width == '0) ? CNT_W'(1)  : width;
      cfg_gap   <= (gap   == '0) ? CNT_W'(1)  : gap;
      cfg_shots <= (shots == '0) ? SHOT_W'(1) : shots;
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: directed bench for glitch_sequencer. Stimulus pushes
// the expected output cycles (any cycle with enable, enable_specific or done
// high) into a queue; a monitor pops and compares whenever the DUT shows one.
module tb_glitch_sequencer;
  import glitch_pkg::*;

  localparam int unsigned CNT_W  = CNT_W_DEF;
  localparam int unsigned SHOT_W = SHOT_W_DEF;

  logic              clk = 1'b0;
  logic              reset;
  logic              arm, abort, trigger, mode;
  logic [CNT_W-1:0]  delay, width, gap;
  logic [SHOT_W-1:0] shots;
  logic              enable, enable_specific, busy, done;
  logic [SHOT_W-1:0] shots_fired;

  glitch_sequencer #(.CNT_W(CNT_W), .SHOT_W(SHOT_W)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
    .mode(mode), .delay(delay), .width(width), .gap(gap), .shots(shots),
    .enable(enable), .enable_specific(enable_specific), .busy(busy),
    .done(done), .shots_fired(shots_fired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic              en;
    logic              sp;
    logic              dn;
    logic [SHOT_W-1:0] sf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input int c, input logic en, input logic sp,
                      input logic dn, input int sf);
    exp_t e;
    e.cyc = c; e.en = en; e.sp = sp; e.dn = dn; e.sf = SHOT_W'(sf);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle with an active output must match the queue head.
  always @(negedge clk) begin
    if (!reset && (enable || enable_specific || done)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: cyc=%0d en=%b sp=%b done=%b sf=%0d, expected none",
                 cyc, enable, enable_specific, done, shots_fired);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.en !== enable || e.sp !== enable_specific ||
            e.dn !== done || e.sf !== shots_fired) begin
          n_bad++;
          $display("FAIL out_event: got cyc=%0d en=%b sp=%b done=%b sf=%0d, expected cyc=%0d en=%b sp=%b done=%b sf=%0d",
                   cyc, enable, enable_specific, done, shots_fired,
                   e.cyc, e.en, e.sp, e.dn, e.sf);
        end
      end
    end
  end

  task automatic do_arm(input logic m, input int d, input int w,
                        input int g, input int s);
    @(negedge clk);
    arm = 1'b1; mode = m;
    delay = CNT_W'(d); width = CNT_W'(w); gap = CNT_W'(g); shots = SHOT_W'(s);
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Raise trigger; returns the cycle number of the detecting edge.
  task automatic fire(output int n);
    @(negedge clk);
    trigger = 1'b1;
    n = cyc + 1;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int k;
    k = 0;
    while (busy && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, max_cyc);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0; mode = 1'b0;
    delay = '0; width = '0; gap = '0; shots = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_enable", int'(enable), 0);
    check("reset_enable_specific", int'(enable_specific), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_shots_fired", int'(shots_fired), 0);

    // Single shot, random mode, delay 3, width 2.
    do_arm(1'b0, 3, 2, 1, 1);
    check("armed_busy", int'(busy), 1);
    fire(n);
    push(n + 4, 1, 0, 0, 0);
    push(n + 5, 1, 0, 0, 0);
    push(n + 6, 0, 0, 1, 1);
    wait_idle("t1_idle", 40);
    check("t1_shots_fired", int'(shots_fired), 1);
    trigger = 1'b0;

    // Three shots, specific mode, delay 0, width 1, gap 2.
    do_arm(1'b1, 0, 1, 2, 3);
    fire(n);
    push(n + 1, 0, 1, 0, 0);
    push(n + 4, 0, 1, 0, 1);
    push(n + 7, 0, 1, 0, 2);
    push(n + 8, 0, 0, 1, 3);
    wait_idle("t2_idle", 40);
    check("t2_shots_fired", int'(shots_fired), 3);

    // Trigger already high at arm must not fire; retrigger in DELAY ignored.
    @(negedge clk);
    trigger = 1'b1;
    do_arm(1'b0, 2, 1, 1, 1);
    repeat (5) @(negedge clk);
    check("t3_held_trigger_busy", int'(busy), 1);
    trigger = 1'b0;
    fire(n);
    push(n + 3, 1, 0, 0, 0);
    push(n + 4, 0, 0, 1, 1);
    @(negedge clk); trigger = 1'b0;
    @(negedge clk); trigger = 1'b1;
    wait_idle("t3_idle", 40);
    check("t3_shots_fired", int'(shots_fired), 1);
    trigger = 1'b0;

    // Abort during 2nd of 4 shots, width 5, gap 2, delay 1.
    do_arm(1'b0, 1, 5, 2, 4);
    fire(n);
    for (int c = 2; c <= 6; c++) push(n + c, 1, 0, 0, 0);
    push(n + 9, 1, 0, 0, 1);
    push(n + 10, 1, 0, 0, 1);
    while (cyc < n + 10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check("t4_abort_enable", int'(enable), 0);
    check("t4_abort_busy", int'(busy), 0);
    check("t4_abort_shots_fired", int'(shots_fired), 1);
    abort = 1'b0;
    trigger = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_after_abort_sf", int'(shots_fired), 1);

    // arm and abort together: abort wins, no arm.
    @(negedge clk);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_busy", int'(busy), 0);

    // Zero width/gap/shots treated as 1; arm while busy is ignored.
    do_arm(1'b0, 0, 0, 0, 0);
    do_arm(1'b1, 5, 4, 3, 3);
    fire(n);
    push(n + 1, 1, 0, 0, 0);
    push(n + 2, 0, 0, 1, 1);
    wait_idle("t5_idle", 40);
    check("t5_shots_fired", int'(shots_fired), 1);
    trigger = 1'b0;

    // Asynchronous reset in the middle of a long pulse.
    do_arm(1'b0, 0, 10, 1, 1);
    fire(n);
    push(n + 1, 1, 0, 0, 0);
    push(n + 2, 1, 0, 0, 0);
    push(n + 3, 1, 0, 0, 0);
    while (cyc < n + 3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_reset_enable", int'(enable), 0);
    check("t6_reset_busy", int'(busy), 0);
    check("t6_reset_shots_fired", int'(shots_fired), 0);
    @(negedge clk);
    reset = 1'b0;
    trigger = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_post_reset_busy", int'(busy), 0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_expected: %0d expected output cycles never seen, expected 0",
               exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
